// File: rtl/ysyx_22040759_wbu.sv
// Writeback unit: retires ALU ops directly and load ops after the memory
// returns data, driving one registered GPR write and a commit pulse per retired op.
module ysyx_22040759_wbu #(
    parameter int XLEN       = 64,
    parameter int RA_W       = 5,
    parameter int LD_TIMEOUT = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [RA_W-1:0] ex_rd,
    input  logic            ex_rf_wen,
    input  logic [XLEN-1:0] ex_result,
    input  logic            ex_is_load,
    input  logic [2:0]      ex_ld_type,
    input  logic [2:0]      ex_addr_lo,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            wen,
    output logic [RA_W-1:0] waddr,
    output logic [XLEN-1:0] wdata,
    output logic            commit_valid,
    output logic [XLEN-1:0] commit_pc,
    output logic [63:0]     instret,
    output logic            err_misalign,
    output logic            err_ldtype,
    output logic            err_timeout,
    output logic            err_spurious
);

    localparam logic [0:0] IDLE      = 1'b0;
    localparam logic [0:0] WAIT_LOAD = 1'b1;

    localparam int                CNT_W    = $clog2(LD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LD_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_TRIP = CNT_W'(LD_TIMEOUT - 1);

    logic [0:0]      state;
    logic [CNT_W-1:0] cnt;

    logic [RA_W-1:0] ld_rd;
    logic            ld_rf_wen;
    logic [2:0]      ld_type;
    logic [2:0]      ld_addr_lo;
    logic [XLEN-1:0] ld_pc;
    logic            ld_bad;

    logic            accept;
    logic            ex_misalign;
    logic            ex_badtype;
    logic [XLEN-1:0] lane;
    logic [XLEN-1:0] ld_data;

    // Handshake: an op transfers on a cycle where ex_valid && ex_ready; the
    // execute stage must hold its payload stable while ex_valid && !ex_ready.
    assign ex_ready = (state == IDLE);
    assign accept   = ex_valid && ex_ready;

    assign ex_badtype = (ex_ld_type == 3'b111);

    always_comb begin
        ex_misalign = 1'b0;
        case (ex_ld_type[1:0])
            2'b00:   ex_misalign = 1'b0;
            2'b01:   ex_misalign = ex_addr_lo[0];
            2'b10:   ex_misalign = (ex_addr_lo[1:0] != 2'b00);
            default: ex_misalign = (ex_addr_lo != 3'b000);
        endcase
    end

    // The doubleword is aligned, so the addressed byte sits at lane addr_lo.
    assign lane = mem_rdata >> {ld_addr_lo, 3'b000};

    always_comb begin
        ld_data = '0;
        case (ld_type)
            3'b000:  ld_data = {{(XLEN-8){lane[7]}}, lane[7:0]};
            3'b001:  ld_data = {{(XLEN-16){lane[15]}}, lane[15:0]};
            3'b010:  ld_data = {{(XLEN-32){lane[31]}}, lane[31:0]};
            3'b011:  ld_data = lane;
            3'b100:  ld_data = {{(XLEN-8){1'b0}}, lane[7:0]};
            3'b101:  ld_data = {{(XLEN-16){1'b0}}, lane[15:0]};
            3'b110:  ld_data = {{(XLEN-32){1'b0}}, lane[31:0]};
            default: ld_data = '0;
        endcase
        if (ld_bad) begin
            ld_data = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            ld_rd        <= '0;
            ld_rf_wen    <= 1'b0;
            ld_type      <= 3'b000;
            ld_addr_lo   <= 3'b000;
            ld_pc        <= '0;
            ld_bad       <= 1'b0;
            wen          <= 1'b0;
            waddr        <= '0;
            wdata        <= '0;
            commit_valid <= 1'b0;
            commit_pc    <= '0;
            instret      <= 64'd0;
            err_misalign <= 1'b0;
            err_ldtype   <= 1'b0;
            err_timeout  <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            wen          <= 1'b0;
            commit_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_rvalid) begin
                        err_spurious <= 1'b1;
                    end
                    if (accept) begin
                        if (ex_is_load) begin
                            state      <= WAIT_LOAD;
                            cnt        <= '0;
                            ld_rd      <= ex_rd;
                            ld_rf_wen  <= ex_rf_wen;
                            ld_type    <= ex_ld_type;
                            ld_addr_lo <= ex_addr_lo;
                            ld_pc      <= ex_pc;
                            ld_bad     <= ex_badtype || ex_misalign;
                            if (ex_badtype) begin
                                err_ldtype <= 1'b1;
                            end else if (ex_misalign) begin
                                err_misalign <= 1'b1;
                            end
                        end else begin
                            wen          <= ex_rf_wen && (ex_rd != '0);
                            waddr        <= ex_rd;
                            wdata        <= ex_result;
                            commit_valid <= 1'b1;
                            commit_pc    <= ex_pc;
                            instret      <= instret + 64'd1;
                        end
                    end
                end
                WAIT_LOAD: begin
                    if (mem_rvalid) begin
                        wen          <= ld_rf_wen && (ld_rd != '0);
                        waddr        <= ld_rd;
                        wdata        <= ld_data;
                        commit_valid <= 1'b1;
                        commit_pc    <= ld_pc;
                        instret      <= instret + 64'd1;
                        state        <= IDLE;
                    end else if (cnt != CNT_MAX) begin
                        // Timeout only flags the stall; the load still waits for data.
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_TRIP) begin
                            err_timeout <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040759_wbu.sv
// Directed bench for the writeback unit: ALU pass-through, load extension,
// error flags, timeout and reset-abandoned loads.
module tb_ysyx_22040759_wbu;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [63:0] ex_pc;
    logic [4:0]  ex_rd;
    logic        ex_rf_wen;
    logic [63:0] ex_result;
    logic        ex_is_load;
    logic [2:0]  ex_ld_type;
    logic [2:0]  ex_addr_lo;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        wen;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic        commit_valid;
    logic [63:0] commit_pc;
    logic [63:0] instret;
    logic        err_misalign;
    logic        err_ldtype;
    logic        err_timeout;
    logic        err_spurious;

    int          n_cmp;
    int          n_fail;
    logic [63:0] exp_instret;

    ysyx_22040759_wbu dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_pc        (ex_pc),
        .ex_rd        (ex_rd),
        .ex_rf_wen    (ex_rf_wen),
        .ex_result    (ex_result),
        .ex_is_load   (ex_is_load),
        .ex_ld_type   (ex_ld_type),
        .ex_addr_lo   (ex_addr_lo),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .wen          (wen),
        .waddr        (waddr),
        .wdata        (wdata),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .instret      (instret),
        .err_misalign (err_misalign),
        .err_ldtype   (err_ldtype),
        .err_timeout  (err_timeout),
        .err_spurious (err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_alu(input logic [4:0] rd, input logic [63:0] res,
                            input logic [63:0] pc, input logic rfw);
        ex_valid   = 1'b1;
        ex_is_load = 1'b0;
        ex_rd      = rd;
        ex_result  = res;
        ex_pc      = pc;
        ex_rf_wen  = rfw;
        step(1);
        ex_valid   = 1'b0;
    endtask

    task automatic send_load(input logic [2:0] ty, input logic [2:0] alo,
                             input logic [4:0] rd, input logic [63:0] pc);
        ex_valid   = 1'b1;
        ex_is_load = 1'b1;
        ex_ld_type = ty;
        ex_addr_lo = alo;
        ex_rd      = rd;
        ex_pc      = pc;
        ex_rf_wen  = 1'b1;
        ex_result  = 64'hAAAA_AAAA_AAAA_AAAA;
        step(1);
        ex_valid   = 1'b0;
        ex_is_load = 1'b0;
    endtask

    task automatic mem_resp(input logic [63:0] data);
        mem_rvalid = 1'b1;
        mem_rdata  = data;
        step(1);
        mem_rvalid = 1'b0;
    endtask

    task automatic chk_commit(input string tag, input logic exp_wen, input logic [4:0] exp_rd,
                              input logic [63:0] exp_data, input logic [63:0] exp_pc);
        exp_instret = exp_instret + 64'd1;
        chk({tag, ".commit_valid"}, {63'd0, commit_valid}, 64'd1);
        chk({tag, ".wen"}, {63'd0, wen}, {63'd0, exp_wen});
        chk({tag, ".waddr"}, {59'd0, waddr}, {59'd0, exp_rd});
        chk({tag, ".wdata"}, wdata, exp_data);
        chk({tag, ".commit_pc"}, commit_pc, exp_pc);
        chk({tag, ".instret"}, instret, exp_instret);
        chk({tag, ".ex_ready"}, {63'd0, ex_ready}, 64'd1);
    endtask

    initial begin
        n_cmp       = 0;
        n_fail      = 0;
        exp_instret = 64'd0;
        rst         = 1'b1;
        ex_valid    = 1'b0;
        ex_pc       = '0;
        ex_rd       = '0;
        ex_rf_wen   = 1'b0;
        ex_result   = '0;
        ex_is_load  = 1'b0;
        ex_ld_type  = 3'b000;
        ex_addr_lo  = 3'b000;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;

        // Reset state
        step(2);
        chk("rst.wen", {63'd0, wen}, 64'd0);
        chk("rst.commit_valid", {63'd0, commit_valid}, 64'd0);
        chk("rst.wdata", wdata, 64'd0);
        chk("rst.instret", instret, 64'd0);
        chk("rst.ex_ready", {63'd0, ex_ready}, 64'd1);
        chk("rst.errs", {60'd0, err_misalign, err_ldtype, err_timeout, err_spurious}, 64'd0);
        rst = 1'b0;
        step(1);

        // ALU pass-through, then pulse drop with held data
        send_alu(5'd5, 64'h1234, 64'h8000_0000, 1'b1);
        chk_commit("alu", 1'b1, 5'd5, 64'h1234, 64'h8000_0000);
        step(1);
        chk("alu.wen_drop", {63'd0, wen}, 64'd0);
        chk("alu.cv_drop", {63'd0, commit_valid}, 64'd0);
        chk("alu.wdata_hold", wdata, 64'h1234);

        // rd==0 still commits
        send_alu(5'd0, 64'h55, 64'h8000_0004, 1'b1);
        chk_commit("alu_rd0", 1'b0, 5'd0, 64'h55, 64'h8000_0004);

        // LB lane 3 sign-extended; ready low while waiting
        send_load(3'b000, 3'd3, 5'd7, 64'h8000_0008);
        chk("lb.ready0", {63'd0, ex_ready}, 64'd0);
        step(2);
        chk("lb.ready2", {63'd0, ex_ready}, 64'd0);
        chk("lb.no_commit", {63'd0, commit_valid}, 64'd0);
        mem_resp(64'h0000_0000_8000_0000);
        chk_commit("lb", 1'b1, 5'd7, 64'hFFFF_FFFF_FFFF_FF80, 64'h8000_0008);

        send_load(3'b100, 3'd3, 5'd8, 64'h8000_000C);
        mem_resp(64'h0000_0000_8000_0000);
        chk_commit("lbu", 1'b1, 5'd8, 64'h80, 64'h8000_000C);

        send_load(3'b010, 3'd4, 5'd10, 64'h8000_0010);
        chk("lw.ready0", {63'd0, ex_ready}, 64'd0);
        step(1);
        chk("lw.ready1", {63'd0, ex_ready}, 64'd0);
        step(1);
        chk("lw.ready2", {63'd0, ex_ready}, 64'd0);
        mem_resp(64'h8765_4321_0000_0000);
        chk_commit("lw", 1'b1, 5'd10, 64'hFFFF_FFFF_8765_4321, 64'h8000_0010);

        send_load(3'b001, 3'd2, 5'd11, 64'h8000_0014);
        mem_resp(64'h0000_0000_9ABC_0000);
        chk_commit("lh", 1'b1, 5'd11, 64'hFFFF_FFFF_FFFF_9ABC, 64'h8000_0014);

        send_load(3'b101, 3'd6, 5'd12, 64'h8000_0018);
        mem_resp(64'hBEEF_0000_0000_0000);
        chk_commit("lhu", 1'b1, 5'd12, 64'h0000_0000_0000_BEEF, 64'h8000_0018);

        send_load(3'b110, 3'd0, 5'd13, 64'h8000_001C);
        mem_resp(64'h1111_2222_8000_0001);
        chk_commit("lwu", 1'b1, 5'd13, 64'h0000_0000_8000_0001, 64'h8000_001C);
        chk("aligned.err_misalign", {63'd0, err_misalign}, 64'd0);

        // Misaligned LD returns 0 and sets the sticky flag
        send_load(3'b011, 3'd2, 5'd3, 64'h8000_0020);
        mem_resp(64'hFFFF_FFFF_FFFF_FFFF);
        chk_commit("ld_mis", 1'b1, 5'd3, 64'd0, 64'h8000_0020);
        chk("ld_mis.err_misalign", {63'd0, err_misalign}, 64'd1);
        chk("ld_mis.err_ldtype", {63'd0, err_ldtype}, 64'd0);

        // Illegal funct3
        send_load(3'b111, 3'd0, 5'd4, 64'h8000_0024);
        mem_resp(64'h0123_4567_89AB_CDEF);
        chk_commit("ld111", 1'b1, 5'd4, 64'd0, 64'h8000_0024);
        chk("ld111.err_ldtype", {63'd0, err_ldtype}, 64'd1);

        // Timeout: flag rises after LD_TIMEOUT idle cycles, load still completes
        send_load(3'b010, 3'd0, 5'd9, 64'h8000_0028);
        step(250);
        chk("to.early", {63'd0, err_timeout}, 64'd0);
        step(10);
        chk("to.flag", {63'd0, err_timeout}, 64'd1);
        chk("to.no_commit", {63'd0, commit_valid}, 64'd0);
        chk("to.ready", {63'd0, ex_ready}, 64'd0);
        mem_resp(64'h1122_3344_5566_7788);
        chk_commit("to", 1'b1, 5'd9, 64'h0000_0000_5566_7788, 64'h8000_0028);
        chk("to.err_spurious", {63'd0, err_spurious}, 64'd0);

        // Reset mid-load abandons it; late response is spurious
        send_load(3'b011, 3'd0, 5'd2, 64'h8000_002C);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        exp_instret = 64'd0;
        chk("rst2.instret", instret, 64'd0);
        chk("rst2.ready", {63'd0, ex_ready}, 64'd1);
        chk("rst2.errs", {60'd0, err_misalign, err_ldtype, err_timeout, err_spurious}, 64'd0);
        mem_resp(64'h0000_0000_0000_DEAD);
        chk("sp.commit_valid", {63'd0, commit_valid}, 64'd0);
        chk("sp.wen", {63'd0, wen}, 64'd0);
        chk("sp.err_spurious", {63'd0, err_spurious}, 64'd1);
        chk("sp.instret", instret, 64'd0);

        send_alu(5'd31, 64'hCAFE_F00D, 64'h8000_0030, 1'b1);
        chk_commit("post", 1'b1, 5'd31, 64'hCAFE_F00D, 64'h8000_0030);
        chk("post.err_spurious", {63'd0, err_spurious}, 64'd1);

        // rf_wen=0 suppresses the write but not the commit
        send_alu(5'd6, 64'h77, 64'h8000_0034, 1'b0);
        chk_commit("nowen", 1'b0, 5'd6, 64'h77, 64'h8000_0034);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
